// File: rtl/brownout_monitor_mc_pkg.sv
// Shared types for the multi-channel brownout monitor: per-channel FSM encoding
// and default widths used by the top and the channel sub-module.
package brownout_monitor_mc_pkg;

    typedef enum logic [1:0] {
        ST_NORMAL  = 2'd0,
        ST_SUSPECT = 2'd1,
        ST_BROWN   = 2'd2,
        ST_RECOVER = 2'd3
    } bod_state_t;

    localparam int N_CH_DEF   = 4;
    localparam int ADC_W_DEF  = 20;
    localparam int RATE_W_DEF = 12;
    // Debounce counters saturate at all-ones of this width rather than wrapping.
    localparam int DEB_W_DEF  = 8;

    function automatic logic is_brown(input bod_state_t s);
        return (s == ST_BROWN) || (s == ST_RECOVER);
    endfunction

endpackage

// File: rtl/bod_channel.sv
// One supply rail: level and slew comparison, debounce counter, previous-sample
// register and the NORMAL/SUSPECT/BROWN/RECOVER state machine.
module bod_channel
    import brownout_monitor_mc_pkg::*;
#(
    parameter int ADC_W  = ADC_W_DEF,
    parameter int RATE_W = RATE_W_DEF,
    parameter int DEB_W  = DEB_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sample_valid,
    input  logic [ADC_W-1:0]  cur,
    input  logic [ADC_W-1:0]  thresh1,
    input  logic [ADC_W-1:0]  thresh2,
    input  logic [RATE_W-1:0] rate_limit,
    input  logic [DEB_W-1:0]  debounce,
    output bod_state_t        state,
    output bod_state_t        state_next
);

    localparam logic [DEB_W-1:0] CNT_ONE = DEB_W'(1);

    // sample_valid is a pure qualifier with no back-pressure: a sample is consumed
    // on every rising edge where it is high, and all state holds when it is low.
    bod_state_t        state_q, state_d;
    logic [DEB_W-1:0]  cnt_q, cnt_d;
    logic [ADC_W-1:0]  prev_q;
    logic              prev_valid_q;

    logic [ADC_W-1:0]  drop;
    logic [DEB_W-1:0]  d_eff;
    logic [DEB_W-1:0]  cnt_inc;
    logic              trip, ok, d_one, inc_done;

    assign drop     = (cur < prev_q) ? (prev_q - cur) : '0;
    assign trip     = (cur < thresh1) | (prev_valid_q & (drop > ADC_W'(rate_limit)));
    assign ok       = (cur >= thresh2);
    assign d_eff    = (debounce == '0) ? CNT_ONE : debounce;
    assign d_one    = (d_eff == CNT_ONE);
    assign cnt_inc  = (&cnt_q) ? cnt_q : (cnt_q + CNT_ONE);
    assign inc_done = (cnt_inc >= d_eff);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (sample_valid) begin
            unique case (state_q)
                ST_NORMAL: begin
                    if (trip) begin
                        state_d = d_one ? ST_BROWN : ST_SUSPECT;
                        cnt_d   = d_one ? '0 : CNT_ONE;
                    end
                end
                ST_SUSPECT: begin
                    if (!trip) begin
                        state_d = ST_NORMAL;
                        cnt_d   = '0;
                    end else if (inc_done) begin
                        state_d = ST_BROWN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d   = cnt_inc;
                    end
                end
                // Recovery only restarts on a sample below thresh2; slew trips are ignored here.
                ST_BROWN: begin
                    if (ok) begin
                        state_d = d_one ? ST_NORMAL : ST_RECOVER;
                        cnt_d   = d_one ? '0 : CNT_ONE;
                    end
                end
                ST_RECOVER: begin
                    if (!ok) begin
                        state_d = ST_BROWN;
                        cnt_d   = '0;
                    end else if (inc_done) begin
                        state_d = ST_NORMAL;
                        cnt_d   = '0;
                    end else begin
                        cnt_d   = cnt_inc;
                    end
                end
                default: begin
                    state_d = ST_NORMAL;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_NORMAL;
            cnt_q        <= '0;
            prev_q       <= '0;
            prev_valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (sample_valid) begin
                prev_q       <= cur;
                prev_valid_q <= 1'b1;
            end
        end
    end

    assign state      = state_q;
    assign state_next = state_d;

endmodule

// File: rtl/brownout_monitor_mc.sv
// Multi-rail brownout monitor: one bod_channel per rail, registered per-channel
// brownout flags, their OR, and sticky "has browned out" latches.
module brownout_monitor_mc
    import brownout_monitor_mc_pkg::*;
#(
    parameter int N_CH   = N_CH_DEF,
    parameter int ADC_W  = ADC_W_DEF,
    parameter int RATE_W = RATE_W_DEF,
    parameter int DEB_W  = DEB_W_DEF
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  SAMPLE_VALID,
    input  logic [N_CH*ADC_W-1:0] ADC_IN,
    input  logic [ADC_W-1:0]      BOD_THRESH1,
    input  logic [ADC_W-1:0]      BOD_THRESH2,
    input  logic [RATE_W-1:0]     RATE_LIMIT,
    input  logic [DEB_W-1:0]      DEBOUNCE,
    input  logic                  CLEAR,
    output logic [N_CH-1:0]       BROWNOUT,
    output logic                  BROWNOUT_ANY,
    output logic [N_CH-1:0]       STICKY
);

    bod_state_t      ch_state [N_CH];
    bod_state_t      ch_next  [N_CH];
    logic [N_CH-1:0] brown_d;
    logic [N_CH-1:0] enter_brown;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        bod_channel #(
            .ADC_W  (ADC_W),
            .RATE_W (RATE_W),
            .DEB_W  (DEB_W)
        ) u_ch (
            .clk          (CLK),
            .rst          (RST),
            .sample_valid (SAMPLE_VALID),
            .cur          (ADC_IN[i*ADC_W +: ADC_W]),
            .thresh1      (BOD_THRESH1),
            .thresh2      (BOD_THRESH2),
            .rate_limit   (RATE_LIMIT),
            .debounce     (DEBOUNCE),
            .state        (ch_state[i]),
            .state_next   (ch_next[i])
        );
    end

    // Sticky sets only on a fresh entry into BROWN, never on RECOVER falling back.
    always_comb begin
        brown_d     = '0;
        enter_brown = '0;
        for (int i = 0; i < N_CH; i++) begin
            brown_d[i]     = is_brown(ch_next[i]);
            enter_brown[i] = !is_brown(ch_state[i]) && (ch_next[i] == ST_BROWN);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            BROWNOUT     <= '0;
            BROWNOUT_ANY <= 1'b0;
            STICKY       <= '0;
        end else begin
            BROWNOUT     <= brown_d;
            BROWNOUT_ANY <= |brown_d;
            STICKY       <= (STICKY & ~{N_CH{CLEAR}}) | enter_brown;
        end
    end

endmodule

// File: tb/tb_brownout_monitor_mc.sv
// Directed bench for brownout_monitor_mc: a streak-counting reference model
// feeds an expected queue checked every cycle, plus literal spot checks.
module tb_brownout_monitor_mc;

    localparam int N_CH   = 4;
    localparam int ADC_W  = 20;
    localparam int RATE_W = 12;
    localparam int DEB_W  = 8;
    localparam int EXP_W  = 2*N_CH + 1;

    logic                  CLK;
    logic                  RST;
    logic                  SAMPLE_VALID;
    logic [N_CH*ADC_W-1:0] ADC_IN;
    logic [ADC_W-1:0]      BOD_THRESH1;
    logic [ADC_W-1:0]      BOD_THRESH2;
    logic [RATE_W-1:0]     RATE_LIMIT;
    logic [DEB_W-1:0]      DEBOUNCE;
    logic                  CLEAR;
    logic [N_CH-1:0]       BROWNOUT;
    logic                  BROWNOUT_ANY;
    logic [N_CH-1:0]       STICKY;

    brownout_monitor_mc #(
        .N_CH   (N_CH),
        .ADC_W  (ADC_W),
        .RATE_W (RATE_W),
        .DEB_W  (DEB_W)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .SAMPLE_VALID (SAMPLE_VALID),
        .ADC_IN       (ADC_IN),
        .BOD_THRESH1  (BOD_THRESH1),
        .BOD_THRESH2  (BOD_THRESH2),
        .RATE_LIMIT   (RATE_LIMIT),
        .DEBOUNCE     (DEBOUNCE),
        .CLEAR        (CLEAR),
        .BROWNOUT     (BROWNOUT),
        .BROWNOUT_ANY (BROWNOUT_ANY),
        .STICKY       (STICKY)
    );

    // ---------------- clock / reset ----------------
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_cmp  = 0;
    int n_fail = 0;
    int vals [N_CH];

    // ---------------- reference model ----------------
    // Each rail is either brown or not, plus the length of the current run of
    // samples pushing it toward the other side.
    logic [EXP_W-1:0] exp_q [$];
    int m_streak [N_CH];
    bit m_brown  [N_CH];
    bit m_sticky [N_CH];
    int m_prev   [N_CH];
    bit m_pvalid [N_CH];

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            exp_q.delete();
            for (int c = 0; c < N_CH; c++) begin
                m_streak[c] = 0; m_brown[c] = 0; m_sticky[c] = 0;
                m_prev[c] = 0;   m_pvalid[c] = 0;
            end
        end else begin
            logic [EXP_W-1:0] e;
            bit set_now [N_CH];
            int d, cur, drop;
            bit trip, ok;
            d = (DEBOUNCE == 0) ? 1 : int'(DEBOUNCE);
            for (int c = 0; c < N_CH; c++) begin
                set_now[c] = 0;
                if (SAMPLE_VALID) begin
                    cur  = int'(ADC_IN[c*ADC_W +: ADC_W]);
                    drop = (m_pvalid[c] && cur < m_prev[c]) ? m_prev[c] - cur : 0;
                    trip = (cur < int'(BOD_THRESH1)) || (drop > int'(RATE_LIMIT));
                    ok   = (cur >= int'(BOD_THRESH2));
                    if (!m_brown[c]) begin
                        if (trip) begin
                            m_streak[c]++;
                            if (m_streak[c] >= d) begin
                                m_brown[c] = 1; m_streak[c] = 0; set_now[c] = 1;
                            end
                        end else m_streak[c] = 0;
                    end else begin
                        if (ok) begin
                            m_streak[c]++;
                            if (m_streak[c] >= d) begin
                                m_brown[c] = 0; m_streak[c] = 0;
                            end
                        end else m_streak[c] = 0;
                    end
                    m_prev[c]   = cur;
                    m_pvalid[c] = 1;
                end
                m_sticky[c] = (m_sticky[c] && !CLEAR) || set_now[c];
            end
            e = '0;
            for (int c = 0; c < N_CH; c++) begin
                e[c]        = m_brown[c];
                e[N_CH + c] = m_sticky[c];
                if (m_brown[c]) e[2*N_CH] = 1'b1;
            end
            exp_q.push_back(e);
        end
    end

    // ---------------- scoreboard compare ----------------
    always @(negedge CLK) begin
        if (!RST && exp_q.size() > 0) begin
            logic [EXP_W-1:0] e;
            e = exp_q.pop_front();
            n_cmp++;
            if ({BROWNOUT_ANY, STICKY, BROWNOUT} !== e) begin
                n_fail++;
                $display("FAIL model_cmp t=%0t got any/sticky/brown=%b expected=%b",
                         $time, {BROWNOUT_ANY, STICKY, BROWNOUT}, e);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic pack_vals();
        for (int c = 0; c < N_CH; c++) ADC_IN[c*ADC_W +: ADC_W] = ADC_W'(vals[c]);
    endtask

    task automatic smp(input int ch, input int v);
        vals[ch] = v;
        pack_vals();
        SAMPLE_VALID = 1'b1;
        @(negedge CLK);
        SAMPLE_VALID = 1'b0;
    endtask

    task automatic idle(input int n);
        SAMPLE_VALID = 1'b0;
        repeat (n) @(negedge CLK);
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        RST = 1'b1; SAMPLE_VALID = 1'b0; CLEAR = 1'b0;
        BOD_THRESH1 = 20'd1000; BOD_THRESH2 = 20'd1200;
        RATE_LIMIT = 12'd4095; DEBOUNCE = 8'd3;
        vals[0] = 5000; vals[1] = 2000; vals[2] = 5000; vals[3] = 5000;
        pack_vals();
        repeat (2) @(negedge CLK);
        check("reset_brown", 32'(BROWNOUT), 0);
        check("reset_any", 32'(BROWNOUT_ANY), 0);
        check("reset_sticky", 32'(STICKY), 0);
        RST = 1'b0;

        // Level trip with debounce of 3
        smp(0, 1500); smp(0, 900); smp(0, 900);
        check("t1_before_third", 32'(BROWNOUT), 32'h0);
        smp(0, 900);
        check("t1_brown", 32'(BROWNOUT), 32'h1);
        check("t1_any", 32'(BROWNOUT_ANY), 1);
        check("t1_sticky", 32'(STICKY), 32'h1);

        // Recovery restarted by a sample below thresh2
        smp(0, 1300); smp(0, 1100); smp(0, 1300); smp(0, 1300);
        check("t2_still_brown", 32'(BROWNOUT), 32'h1);
        smp(0, 1300);
        check("t2_recovered", 32'(BROWNOUT), 32'h0);
        check("t2_any_low", 32'(BROWNOUT_ANY), 0);
        check("t2_sticky_kept", 32'(STICKY), 32'h1);
        CLEAR = 1'b1; idle(1); CLEAR = 1'b0;
        check("t2_sticky_cleared", 32'(STICKY), 32'h0);

        // Slew trip, debounce 1 and 0
        RATE_LIMIT = 12'd100; DEBOUNCE = 8'd1;
        smp(1, 2000); smp(1, 1850);
        check("t3_slew_trip", 32'(BROWNOUT), 32'h2);
        smp(1, 1850);
        check("t3_recover_d1", 32'(BROWNOUT), 32'h0);
        smp(1, 2000); smp(1, 1950);
        check("t3_small_drop", 32'(BROWNOUT), 32'h0);
        DEBOUNCE = 8'd0;
        smp(1, 1800);
        check("t3_d0_trip", 32'(BROWNOUT), 32'h2);
        smp(1, 1800);
        check("t3_d0_recover", 32'(BROWNOUT), 32'h0);
        CLEAR = 1'b1; idle(1); CLEAR = 1'b0;

        // Fresh channel after reset, and state hold without SAMPLE_VALID
        RST = 1'b1; idle(1); RST = 1'b0;
        DEBOUNCE = 8'd3;
        smp(3, 5000);
        check("t4_first_sample", 32'(BROWNOUT), 32'h0);
        ADC_IN = '0; idle(10);
        check("t4_idle_hold", 32'(BROWNOUT), 32'h0);
        smp(3, 4900);
        check("t4_prev_held", 32'(BROWNOUT), 32'h0);
        smp(3, 900); smp(3, 900);
        ADC_IN = '0; idle(10);
        check("t4_suspect_hold", 32'(BROWNOUT), 32'h0);
        smp(3, 900);
        check("t4_count_resumed", 32'(BROWNOUT), 32'h8);
        check("t4_sticky", 32'(STICKY), 32'h8);

        // CLEAR coincident with entering BROWN
        DEBOUNCE = 8'd2;
        smp(2, 900);
        CLEAR = 1'b1;
        smp(2, 900);
        check("t5_set_wins", 32'(STICKY), 32'h4);
        check("t5_brown", 32'(BROWNOUT), 32'hC);
        idle(1); CLEAR = 1'b0;
        check("t5_cleared", 32'(STICKY), 32'h0);
        check("t5_brown_kept", 32'(BROWNOUT), 32'hC);

        // Lowering DEBOUNCE below an in-progress count
        DEBOUNCE = 8'd4;
        smp(0, 900); smp(0, 900); smp(0, 900);
        check("t7_pending", 32'(BROWNOUT), 32'hC);
        DEBOUNCE = 8'd2;
        smp(0, 900);
        check("t7_completed", 32'(BROWNOUT), 32'hD);
        smp(0, 1300); smp(0, 1300);
        check("t7_recovered", 32'(BROWNOUT), 32'hC);

        // Async reset in SUSPECT with count 2
        DEBOUNCE = 8'd3;
        smp(0, 900); smp(0, 900);
        #2 RST = 1'b1;
        #1;
        check("t6_async_brown", 32'(BROWNOUT), 0);
        check("t6_async_any", 32'(BROWNOUT_ANY), 0);
        check("t6_async_sticky", 32'(STICKY), 0);
        @(negedge CLK);
        RST = 1'b0;
        vals[2] = 5000; vals[3] = 5000;
        smp(0, 900); smp(0, 900);
        check("t6_no_partial", 32'(BROWNOUT), 32'h0);
        smp(0, 900);
        check("t6_full_debounce", 32'(BROWNOUT), 32'h1);
        check("t6_sticky", 32'(STICKY), 32'h1);

        // Mixed traffic checked by the model only
        for (int k = 0; k < 60; k++) begin
            BOD_THRESH1 = ADC_W'($urandom_range(950, 1050));
            BOD_THRESH2 = BOD_THRESH1 + ADC_W'($urandom_range(0, 200));
            DEBOUNCE    = DEB_W'($urandom_range(0, 3));
            CLEAR       = ($urandom_range(0, 7) == 0);
            for (int c = 0; c < N_CH; c++) vals[c] = $urandom_range(800, 1400);
            pack_vals();
            SAMPLE_VALID = ($urandom_range(0, 3) != 0);
            @(negedge CLK);
        end
        SAMPLE_VALID = 1'b0; CLEAR = 1'b0;
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
